// File: rtl/vout_timing_mode_ctrl.sv
// Mode controller for the video timing generator: preset/custom timing sets, req/ack handshake,
// frame-aligned switch with generator reset hold. Custom mode 7 is built when VOUT_MODE_CUSTOM_EN is defined.
module vout_timing_mode_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned FRAME_TIMEOUT = 4194304
) (
  input  logic        dp_clk,
  input  logic        rst_n,
  input  logic        mode_req,
  input  logic [2:0]  mode_sel,
  output logic        mode_ack,
  output logic        mode_err,
  output logic        busy,
  output logic [2:0]  cur_mode,
  output logic        mode_valid,
  output logic        timeout,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  input  logic        tg_vs,
  output logic        tg_rst_n,
  output logic [11:0] h_fp,
  output logic [11:0] h_sync,
  output logic [11:0] h_bp,
  output logic [11:0] h_active,
  output logic [11:0] h_total,
  output logic [11:0] v_fp,
  output logic [11:0] v_sync,
  output logic [11:0] v_bp,
  output logic [11:0] v_active,
  output logic [11:0] v_total,
  output logic        hs_pol,
  output logic        vs_pol
);

  localparam int unsigned WCW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, HOLD, RUN} state_t;

  // prm index order: h fp/sync/bp/active/total, then v in the same order
  typedef struct packed {
    logic             vs_pol;
    logic             hs_pol;
    logic [9:0][11:0] prm;
  } tset_t;

  function automatic tset_t mk_set(input logic [11:0] hfp, hsy, hbp, hac, hto,
                                   input logic [11:0] vfp, vsy, vbp, vac, vto,
                                   input logic hp, vp);
    tset_t t;
    t.prm[0] = hfp; t.prm[1] = hsy; t.prm[2] = hbp; t.prm[3] = hac; t.prm[4] = hto;
    t.prm[5] = vfp; t.prm[6] = vsy; t.prm[7] = vbp; t.prm[8] = vac; t.prm[9] = vto;
    t.hs_pol = hp;
    t.vs_pol = vp;
    return t;
  endfunction

  function automatic tset_t preset_set(input logic [1:0] idx);
    case (idx)
      2'd0:    return mk_set(12'd16, 12'd96, 12'd48, 12'd640, 12'd800,
                             12'd10, 12'd2, 12'd33, 12'd480, 12'd525, 1'b0, 1'b0);
      2'd1:    return mk_set(12'd40, 12'd128, 12'd88, 12'd800, 12'd1056,
                             12'd1, 12'd4, 12'd23, 12'd600, 12'd628, 1'b1, 1'b1);
      2'd2:    return mk_set(12'd110, 12'd40, 12'd220, 12'd1280, 12'd1650,
                             12'd5, 12'd5, 12'd20, 12'd720, 12'd750, 1'b1, 1'b1);
      default: return mk_set(12'd88, 12'd44, 12'd148, 12'd1920, 12'd2200,
                             12'd4, 12'd5, 12'd36, 12'd1080, 12'd1125, 1'b1, 1'b1);
    endcase
  endfunction

  tset_t            sel_set;
  logic             sel_ok;
  logic             accept;
  logic             vs_rise;
  logic [WCW-1:0]   wait_cnt_d;

  state_t           state_q;
  tset_t            pend_q;
  logic [2:0]       pend_mode_q;
  tset_t            out_q;
  logic [2:0]       cur_mode_q;
  logic             ack_q;
  logic             err_q;
  logic             tmo_q;
  logic             tg_rst_n_q;
  logic             valid_q;
  logic             busy_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic [7:0]       hold_cnt_q;
  logic             vs_sync_q;
  logic             vs_prev_q;

`ifdef VOUT_MODE_CUSTOM_EN
  localparam tset_t PRESET0 = preset_set(2'd0);

  logic [9:0][11:0] shadow_q;
  logic [1:0]       shadow_pol_q;   // {vs, hs}
  tset_t            custom_set;
  logic             custom_ok;

  function automatic logic axis_ok(input logic [11:0] fp, sy, bp, ac, to);
    logic [13:0] sum;
    sum = {2'b00, fp} + {2'b00, sy} + {2'b00, bp} + {2'b00, ac};
    return (sum == {2'b00, to}) && (sy != 12'd0) && (ac != 12'd0) && (to != 12'd0);
  endfunction

  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= PRESET0.prm;
      shadow_pol_q <= 2'b00;
    end else if (cfg_wr) begin
      if (cfg_addr <= 4'd9) begin
        shadow_q[cfg_addr] <= cfg_wdata;
      end else if (cfg_addr == 4'd10) begin
        shadow_pol_q <= cfg_wdata[1:0];
      end
    end
  end

  assign custom_set = {shadow_pol_q[1], shadow_pol_q[0], shadow_q};
  assign custom_ok  = axis_ok(shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3], shadow_q[4]) &&
                      axis_ok(shadow_q[5], shadow_q[6], shadow_q[7], shadow_q[8], shadow_q[9]);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_wr, cfg_addr, cfg_wdata};
`endif

  always_comb begin
    sel_set = '0;
    sel_ok  = 1'b0;
    if (mode_sel[2] == 1'b0) begin
      sel_set = preset_set(mode_sel[1:0]);
      sel_ok  = 1'b1;
    end
`ifdef VOUT_MODE_CUSTOM_EN
    else if (mode_sel == 3'd7) begin
      sel_set = custom_set;
      sel_ok  = custom_ok;
    end
`endif
  end

  // ack_q blocks the cycle right after an acceptance so a held request re-triggers every other cycle
  assign accept     = mode_req && (state_q == IDLE || state_q == RUN) && !ack_q;
  assign vs_rise    = vs_sync_q && !vs_prev_q;
  assign wait_cnt_d = wait_cnt_q + 1'b1;

  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_mode_q <= 3'd0;
      out_q       <= '0;
      cur_mode_q  <= 3'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      tg_rst_n_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      wait_cnt_q  <= '0;
      hold_cnt_q  <= 8'd0;
      vs_sync_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      vs_sync_q <= tg_vs;
      vs_prev_q <= vs_sync_q;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;

      if (accept) begin
        ack_q <= 1'b1;
        err_q <= !sel_ok;
        if (sel_ok) begin
          pend_q      <= sel_set;
          pend_mode_q <= mode_sel;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept && sel_ok) begin
            state_q    <= HOLD;
            busy_q     <= 1'b1;
            hold_cnt_q <= 8'd0;
          end
        end
        RUN: begin
          if (accept && sel_ok) begin
            state_q    <= WAIT_FRAME;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            wait_cnt_q <= WCW'(1);
          end
        end
        WAIT_FRAME: begin
          if (vs_rise || wait_cnt_q == WCW'(FRAME_TIMEOUT)) begin
            tmo_q      <= !vs_rise;
            out_q      <= pend_q;
            cur_mode_q <= pend_mode_q;
            tg_rst_n_q <= 1'b0;
            state_q    <= HOLD;
            hold_cnt_q <= 8'd1;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          // hold_cnt_q == 0 marks a HOLD entered from IDLE whose parameters are not yet applied
          if (hold_cnt_q == 8'd0) begin
            out_q      <= pend_q;
            cur_mode_q <= pend_mode_q;
            hold_cnt_q <= 8'd1;
          end else if (hold_cnt_q == 8'(RST_CYCLES)) begin
            state_q    <= RUN;
            tg_rst_n_q <= 1'b1;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign mode_ack   = ack_q;
  assign mode_err   = err_q;
  assign busy       = busy_q;
  assign cur_mode   = cur_mode_q;
  assign mode_valid = valid_q;
  assign timeout    = tmo_q;
  assign tg_rst_n   = tg_rst_n_q;
  assign h_fp       = out_q.prm[0];
  assign h_sync     = out_q.prm[1];
  assign h_bp       = out_q.prm[2];
  assign h_active   = out_q.prm[3];
  assign h_total    = out_q.prm[4];
  assign v_fp       = out_q.prm[5];
  assign v_sync     = out_q.prm[6];
  assign v_bp       = out_q.prm[7];
  assign v_active   = out_q.prm[8];
  assign v_total    = out_q.prm[9];
  assign hs_pol     = out_q.hs_pol;
  assign vs_pol     = out_q.vs_pol;

endmodule

// File: doc/vout_timing_mode_ctrl.md
# vout_timing_mode_ctrl

Mode controller for the video output timing generator. Holds four preset CEA/VESA timing sets and one optional host-programmable set. Accepts mode-change requests over a req/ack handshake, waits for a frame boundary from the running generator, then applies the new parameters atomically while holding the generator in reset. It sits between the host/config logic and the timing generator's parameter and reset inputs.

## Interface
- RST_CYCLES, 16: generator reset hold length in dp_clk cycles (1..255).
- FRAME_TIMEOUT, 4194304: cycles to wait for a frame boundary before forcing the switch (2..2^23-1).
- dp_clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_req  in  1  level request; sampled only when the controller can accept.
- mode_sel  in  3  0=640x480, 1=800x600, 2=1280x720, 3=1920x1080, 7=custom, 4-6 invalid.
- mode_ack  out  1  one-cycle pulse: request consumed.
- mode_err  out  1  one-cycle pulse coincident with mode_ack: request rejected.
- busy  out  1  high in WAIT_FRAME and HOLD.
- cur_mode  out  3  mode_sel of the applied mode.
- mode_valid  out  1  high in RUN.
- timeout  out  1  one-cycle pulse when the frame wait expires.
- cfg_wr  in  1  custom-register write strobe.
- cfg_addr  in  4  0-4 = h_fp,h_sync,h_bp,h_active,h_total; 5-9 = same order for v; 10 = polarity {vs,hs} in bits [1:0].
- cfg_wdata  in  12  write data.
- tg_vs  in  1  vs output of the timing generator.
- tg_rst_n  out  1  active-low reset to the timing generator.
- h_fp, h_sync, h_bp, h_active, h_total, v_fp, v_sync, v_bp, v_active, v_total  out  12 each  applied timing parameters.
- hs_pol, vs_pol  out  1 each  sync polarity, 1 = active high.

## Operation
- States: IDLE, WAIT_FRAME, HOLD, RUN.
- Requests are accepted only in IDLE or RUN. A request raised in WAIT_FRAME or HOLD stays pending until RUN.
- Acceptance: the selected set is copied into a pending register and mode_ack pulses.
  - Invalid requests also pulse mode_err; state and outputs are unchanged.
- Invalid request conditions:
  - mode_sel 4-6.
  - Custom set failing validation: fp+sync+bp+active != total, computed at 14 bits with no wrap, on either axis; or any of sync, active, total equal to zero.
- Transitions after a valid acceptance:
  - IDLE -> HOLD.
  - RUN -> WAIT_FRAME.
  - WAIT_FRAME -> HOLD on a tg_vs rising edge (registered edge detect), or when the wait counter reaches FRAME_TIMEOUT (pulse timeout).
  - HOLD -> RUN after RST_CYCLES cycles.
- On HOLD entry, the pending register is loaded onto all parameter and polarity outputs and cur_mode in one cycle. tg_rst_n = 0 throughout HOLD.
- tg_rst_n = 1 only in RUN and WAIT_FRAME. The old mode keeps running until the boundary.
- Preset values as h fp/sync/bp/active/total; v same; pol hs,vs:
  - 0: 16/96/48/640/800; 10/2/33/480/525; neg,neg.
  - 1: 40/128/88/800/1056; 1/4/23/600/628; pos,pos.
  - 2: 110/40/220/1280/1650; 5/5/20/720/750; pos,pos.
  - 3: 88/44/148/1920/2200; 4/5/36/1080/1125; pos,pos.
- Custom shadow registers accept writes in every state. Writes never affect the outputs directly; they take effect only through a later accepted mode 7 request.
- Shadow reset values equal preset 0. Writes to addresses 11-15 are ignored.

## Timing
- Reset values: state IDLE, tg_rst_n 0, all parameter outputs 0, hs_pol/vs_pol 0, cur_mode 0, mode_valid/busy/mode_ack/mode_err/timeout 0.
- Reset asserted mid-operation returns to IDLE immediately. Any pending request is dropped.
- Acceptance cycle: mode_ack is registered, visible the cycle after mode_req is sampled high.
- The next acceptance is possible no earlier than 2 cycles later. A held-high mode_req therefore re-triggers, so the host drops mode_req on mode_ack.
- IDLE path: outputs change 1 cycle after mode_ack. tg_rst_n rises exactly RST_CYCLES cycles after the outputs change; mode_valid rises the same cycle.
- RUN path: outputs change 2 cycles after the tg_vs rising edge (sync stage plus edge register).
- Timeout: pulses on the cycle the counter equals FRAME_TIMEOUT; the switch follows as on an edge.
- Edge and timeout in the same cycle: treated as an edge; no timeout pulse.
- cfg_wr and acceptance of mode 7 in the same cycle: the pending set and validation use the pre-write shadow values.

## Configuration
- VOUT_MODE_CUSTOM_EN defined: custom shadow registers, the cfg_* write path and mode 7 are present.
- Not defined: cfg_* inputs are ignored, no shadow registers exist, and mode_sel 7 is rejected with mode_err like 4-6.

## Test plan
- Reset, request mode 2 from IDLE -> mode_ack one pulse; h_total=1650, v_total=750; tg_rst_n low 16 cycles then high; mode_valid 1, cur_mode 2.
- In RUN mode 2, request mode 3 with the generator running -> outputs stay at mode 2 until tg_vs rises, switch to h_total=2200 two cycles later, then a 16-cycle tg_rst_n low pulse.
- In RUN, request mode 5 -> mode_ack and mode_err in the same cycle; cur_mode, parameters and tg_rst_n unchanged.
- Custom write h_total=1000 with h_fp/sync/bp/active summing to 800, request 7 -> mode_err. Rewrite h_total=800, request 7 -> accepted, h_total=800.
- FRAME_TIMEOUT=100, tg_vs tied low, in RUN request mode 1 -> timeout pulse 100 cycles after entering WAIT_FRAME, then switch to h_total=1056.
- Assert rst_n during HOLD -> tg_rst_n 0, all outputs 0 and state IDLE immediately; after release, no spontaneous mode_ack.
